// File: rtl/hamming_dec21.sv
// Hamming(21,16) receive-side decoder: two-stage valid/ready pipeline with single-bit correction.
// Optional saturating error counters are built when HAMMING_DEC_ERRCNT_EN is defined.
module hamming_dec21 #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [20:0]      in_cw,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [15:0]      out_data,
    output logic [4:0]       out_syndrome,
    output logic             out_err_corr,
    output logic             out_err_uncorr,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_corr,
    output logic [CNT_W-1:0] cnt_uncorr
);

    // Syndrome bit k collects every position whose 1-based index has bit k set.
    function automatic logic [4:0] calc_syndrome(input logic [20:0] cw);
        logic [4:0] syn;
        logic [4:0] pos;
        syn = 5'd0;
        for (int i = 0; i < 21; i++) begin
            pos = 5'(i + 1);
            syn = syn ^ ({5{cw[i]}} & pos);
        end
        return syn;
    endfunction

    function automatic logic [15:0] extract_data(input logic [20:0] cw);
        return {cw[20:16], cw[14:8], cw[6:4], cw[2]};
    endfunction

    logic        r_s1_valid;
    logic [20:0] r_s1_cw;
    logic        r_out_valid;
    logic [15:0] r_out_data;
    logic [4:0]  r_out_syndrome;
    logic        r_out_err_corr;
    logic        r_out_err_uncorr;

    logic        w_adv2;
    logic        w_in_xfer;
    logic [4:0]  w_syn;
    logic [20:0] w_flip_mask;
    logic        w_corr_en;
    logic        w_uncorr;
    logic [15:0] w_data;

    assign w_adv2    = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready  = ~r_s1_valid | w_adv2;
    assign w_in_xfer = in_valid & in_ready;

    // Syndrome decode and single-bit correction of the word held in stage 1.
    always_comb begin
        w_syn       = calc_syndrome(r_s1_cw);
        w_flip_mask = 21'd0;
        w_corr_en   = 1'b0;
        w_uncorr    = 1'b0;
        if ((w_syn != 5'd0) && (w_syn <= 5'd21)) begin
            w_corr_en   = 1'b1;
            w_flip_mask = 21'd1 << (w_syn - 5'd1);
        end else if (w_syn >= 5'd22) begin
            w_uncorr = 1'b1;
        end else begin
            w_corr_en = 1'b0;
        end
        w_data = extract_data(r_s1_cw ^ w_flip_mask);
    end

    // Stage 1: capture the incoming codeword; holds while stage 2 is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_cw    <= 21'd0;
        end else if (w_in_xfer) begin
            r_s1_valid <= 1'b1;
            r_s1_cw    <= in_cw;
        end else if (w_adv2) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: register decoded results; frozen while out_valid && !out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid      <= 1'b0;
            r_out_data       <= 16'd0;
            r_out_syndrome   <= 5'd0;
            r_out_err_corr   <= 1'b0;
            r_out_err_uncorr <= 1'b0;
        end else if (w_adv2) begin
            r_out_valid      <= 1'b1;
            r_out_data       <= w_data;
            r_out_syndrome   <= w_syn;
            r_out_err_corr   <= w_corr_en;
            r_out_err_uncorr <= w_uncorr;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_syndrome   = r_out_syndrome;
    assign out_err_corr   = r_out_err_corr;
    assign out_err_uncorr = r_out_err_uncorr;

`ifdef HAMMING_DEC_ERRCNT_EN
    logic             w_out_xfer;
    logic [CNT_W-1:0] r_cnt_corr;
    logic [CNT_W-1:0] r_cnt_uncorr;

    assign w_out_xfer = r_out_valid & out_ready;

    // Saturating error counters; clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else begin
            if (w_out_xfer && r_out_err_corr && !(&r_cnt_corr)) begin
                r_cnt_corr <= r_cnt_corr + 1'b1;
            end
            if (w_out_xfer && r_out_err_uncorr && !(&r_cnt_uncorr)) begin
                r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
            end
        end
    end

    assign cnt_corr   = r_cnt_corr;
    assign cnt_uncorr = r_cnt_uncorr;
`else
    logic w_unused;

    assign w_unused   = cnt_clr;
    assign cnt_corr   = '0;
    assign cnt_uncorr = '0;
`endif

endmodule

// File: tb/tb_hamming_dec21.sv
// Directed self-checking bench for hamming_dec21 (counter checks adapt to HAMMING_DEC_ERRCNT_EN).
module tb_hamming_dec21;

`ifdef HAMMING_DEC_ERRCNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [20:0] in_cw;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_syndrome;
    logic        out_err_corr;
    logic        out_err_uncorr;
    logic        out_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [1:0]  cnt_corr;
    logic [1:0]  cnt_uncorr;

    int checks = 0;
    int failures = 0;

    hamming_dec21 #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .in_cw(in_cw), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_syndrome(out_syndrome), .out_err_corr(out_err_corr),
        .out_err_uncorr(out_err_uncorr), .out_valid(out_valid), .out_ready(out_ready),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent encoder: place data, then set each parity so its syndrome bit is 0.
    function automatic logic [20:0] enc(input logic [15:0] m);
        logic [20:0] cw;
        int dpos [16];
        logic p;
        dpos = '{2, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 16, 17, 18, 19, 20};
        cw = 21'd0;
        for (int i = 0; i < 16; i++) cw[dpos[i]] = m[i];
        for (int j = 0; j < 5; j++) begin
            p = 1'b0;
            for (int i = 0; i < 21; i++) if ((((i + 1) >> j) & 1) != 0) p = p ^ cw[i];
            cw[(1 << j) - 1] = p;
        end
        return cw;
    endfunction

    task automatic send_one(input string tag, input logic [20:0] cw, input logic [15:0] d,
                            input logic [4:0] s, input logic c, input logic u, input bit clr_at_out);
        int n;
        @(negedge clk);
        in_cw = cw; in_valid = 1'b1; out_ready = 1'b1;
        #1 check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_latency"}, 32'(n), 32'd2);
        check_eq({tag, "_data"}, 32'(out_data), 32'(d));
        check_eq({tag, "_syn"}, 32'(out_syndrome), 32'(s));
        check_eq({tag, "_corr"}, 32'(out_err_corr), 32'(c));
        check_eq({tag, "_uncorr"}, 32'(out_err_uncorr), 32'(u));
        if (clr_at_out) cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
    endtask

    logic [15:0] bp_msg  [8] = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF, 16'h8001, 16'h5A5A, 16'hC3C3, 16'h7FFE};
    logic [20:0] bp_flip [8] = '{21'h000000, 21'h100000, 21'h000001, 21'h000000, 21'h000200, 21'h008000, 21'h000000, 21'h000004};
    logic [4:0]  bp_syn  [8] = '{5'd0, 5'd21, 5'd1, 5'd0, 5'd10, 5'd16, 5'd0, 5'd3};

    initial begin
        int sent;
        int got;
        int cyc;
        bit stall;
        logic [15:0] hd;
        logic [4:0] hs;

        rst = 1'b1; in_valid = 1'b0; in_cw = 21'd0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_data", 32'(out_data), 32'd0);
        check_eq("rst_syn", 32'(out_syndrome), 32'd0);
        check_eq("rst_flags", 32'({out_err_corr, out_err_uncorr}), 32'd0);
        check_eq("rst_cnt", 32'({cnt_corr, cnt_uncorr}), 32'd0);

        send_one("clean",   21'h1FFFFE, 16'hFFFF, 5'd0,  1'b0, 1'b0, 1'b0);
        send_one("dbit20",  21'h0FFFFE, 16'hFFFF, 5'd21, 1'b1, 1'b0, 1'b0);
        send_one("uncorr",  21'h008080, 16'h0000, 5'd24, 1'b0, 1'b1, 1'b0);
        send_one("alias",   21'h000003, 16'h0001, 5'd3,  1'b1, 1'b0, 1'b0);
        send_one("pbit0",   21'h1FFFFF, 16'hFFFF, 5'd1,  1'b1, 1'b0, 1'b0);
        send_one("dbit9",   21'h000200, 16'h0000, 5'd10, 1'b1, 1'b0, 1'b0);
        send_one("zero",    21'h000000, 16'h0000, 5'd0,  1'b0, 1'b0, 1'b0);
        send_one("dbit4",   21'h000010, 16'h0000, 5'd5,  1'b1, 1'b0, 1'b0);

        check_eq("cnt_corr_sat", 32'(cnt_corr), CNT_ON ? 32'd3 : 32'd0);
        check_eq("cnt_uncorr_one", 32'(cnt_uncorr), CNT_ON ? 32'd1 : 32'd0);

        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        check_eq("cnt_clr_corr", 32'(cnt_corr), 32'd0);
        check_eq("cnt_clr_uncorr", 32'(cnt_uncorr), 32'd0);

        for (int i = 0; i < 5; i++) send_one("five", 21'h0FFFFE, 16'hFFFF, 5'd21, 1'b1, 1'b0, 1'b0);
        check_eq("cnt_five_sat", 32'(cnt_corr), CNT_ON ? 32'd3 : 32'd0);
        send_one("clr_prio", 21'h1FFFFF, 16'hFFFF, 5'd1, 1'b1, 1'b0, 1'b1);
        check_eq("cnt_clr_priority", 32'(cnt_corr), 32'd0);

        // Backpressure stream with out_ready toggling every cycle.
        sent = 0; got = 0; cyc = 0; stall = 1'b0; hd = 16'd0; hs = 5'd0;
        while (got < 8 && cyc < 100) begin
            @(negedge clk);
            if (stall) begin
                check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
                check_eq("bp_hold_data", 32'(out_data), 32'(hd));
                check_eq("bp_hold_syn", 32'(out_syndrome), 32'(hs));
            end
            out_ready = ((cyc % 2) == 0);
            in_valid = (sent < 8);
            if (sent < 8) in_cw = enc(bp_msg[sent]) ^ bp_flip[sent];
            #1;
            if (out_valid && out_ready) begin
                check_eq("bp_data", 32'(out_data), 32'(bp_msg[got]));
                check_eq("bp_syn", 32'(out_syndrome), 32'(bp_syn[got]));
                got++;
            end
            if (in_valid && in_ready) sent++;
            stall = out_valid && !out_ready;
            hd = out_data;
            hs = out_syndrome;
            cyc++;
        end
        check_eq("bp_count", 32'(got), 32'd8);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("bp_no_extra", 32'(out_valid), 32'd0);
        end

        // Fill both stages under stall, then reset.
        @(negedge clk); cnt_clr = 1'b1;
        @(negedge clk); cnt_clr = 1'b0;
        out_ready = 1'b0; in_valid = 1'b1; in_cw = 21'h0FFFFE;
        @(negedge clk); in_cw = 21'h1FFFFF;
        @(negedge clk);
        #1;
        check_eq("full_in_ready", 32'(in_ready), 32'd0);
        check_eq("full_out_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0; rst = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("mrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("mrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mrst_data", 32'(out_data), 32'd0);
        check_eq("mrst_syn", 32'(out_syndrome), 32'd0);
        check_eq("mrst_flags", 32'({out_err_corr, out_err_uncorr}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("mrst_no_emit", 32'(out_valid), 32'd0);
            check_eq("mrst_cnt", 32'(cnt_corr), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
